// File: rtl/key_speed_pkg.sv
// Shared width, default speed table, FSM encoding and index-to-rate lookup for key_speed_ctrl.
package key_speed_pkg;

    localparam int RATE_W = 27;
    localparam int SPEED0 = 250000;
    localparam int SPEED1 = 2500000;
    localparam int SPEED2 = 25000000;
    localparam int SPEED3 = 125000000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        PRESSED   = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    function automatic logic [RATE_W-1:0] speed_of(
        input logic [1:0] idx,
        input int         s0,
        input int         s1,
        input int         s2,
        input int         s3
    );
        logic [RATE_W-1:0] r;
        case (idx)
            2'd0:    r = RATE_W'(s0);
            2'd1:    r = RATE_W'(s1);
            2'd2:    r = RATE_W'(s2);
            default: r = RATE_W'(s3);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw key; resets to 1 (released). Latency 2 edges, no backpressure.
module key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic dout_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din_i};
        end
    end

    assign dout_o = sync_q[1];
endmodule

// File: rtl/key_speed_ctrl.sv
// Debounced key front end stepping a 4-entry speed table; press strobes DEBOUNCE_CYCLES+3 edges after key_n falls.
// KEY_LONG_PRESS_EN adds a long-hold return to SPEED0 with long_pulse; otherwise long_pulse is 0.
module key_speed_ctrl #(
    parameter int RATE_W            = key_speed_pkg::RATE_W,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int SPEED0            = key_speed_pkg::SPEED0,
    parameter int SPEED1            = key_speed_pkg::SPEED1,
    parameter int SPEED2            = key_speed_pkg::SPEED2,
    parameter int SPEED3            = key_speed_pkg::SPEED3,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_n,
    output logic [RATE_W-1:0] rate,
    output logic [1:0]        speed_idx,
    output logic              press_pulse,
    output logic              key_level,
    output logic              long_pulse
);
    import key_speed_pkg::*;

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_cfg
        $error("key_speed_ctrl: cycle-count parameters must be >= 1");
    end

    logic              ks;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        speed_idx_q;
    logic [RATE_W-1:0] rate_q;
    logic              press_q;
    logic              long_q;

    logic              accept_d;
    logic              long_fire_d;
    logic [1:0]        idx_inc_d;
    logic [RATE_W-1:0] rate_inc_d;

    key_sync u_key_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (key_n),
        .dout_o (ks)
    );

    assign accept_d   = (state_q == PRESS_CHK) && !ks && (cnt_q == CNT_LAST);
    assign idx_inc_d  = speed_idx_q + 2'd1;
    assign rate_inc_d = RATE_W'(speed_of(idx_inc_d, SPEED0, SPEED1, SPEED2, SPEED3));

`ifdef KEY_LONG_PRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic [HOLD_W-1:0] hold_q;
    logic              fired_q;
    logic              hold_run;

    // Only counts in PRESSED: REL_CHK bounces freeze the count instead of clearing it.
    assign hold_run    = (state_q == PRESSED) && !ks && !fired_q;
    assign long_fire_d = hold_run && (hold_q == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
        end else if (accept_d) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
        end else if (long_fire_d) begin
            fired_q <= 1'b1;
        end else if (hold_run) begin
            hold_q  <= hold_q + 1'b1;
        end
    end
`else
    assign long_fire_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            speed_idx_q <= 2'd0;
            rate_q      <= RATE_W'(SPEED0);
            press_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            press_q <= accept_d;
            long_q  <= long_fire_d;

            case (state_q)
                IDLE: begin
                    if (!ks) begin
                        state_q <= PRESS_CHK;
                        cnt_q   <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (ks) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (ks) begin
                        state_q <= REL_CHK;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (!ks) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase

            // Acceptance lives in PRESS_CHK, long press in PRESSED, so they never collide.
            if (accept_d) begin
                speed_idx_q <= idx_inc_d;
                rate_q      <= rate_inc_d;
            end else if (long_fire_d) begin
                speed_idx_q <= 2'd0;
                rate_q      <= RATE_W'(SPEED0);
            end
        end
    end

    assign rate        = rate_q;
    assign speed_idx   = speed_idx_q;
    assign press_pulse = press_q;
    assign long_pulse  = long_q;
    assign key_level   = (state_q == PRESSED) || (state_q == REL_CHK);
endmodule

// File: tb/tb_key_speed_ctrl.sv
// Directed and random key patterns checked cycle by cycle against a run-length key model.
`timescale 1ns/1ps
module tb_key_speed_ctrl;
    localparam int D  = 4;
    localparam int L  = 10;
    localparam int RW = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_n;
    logic [RW-1:0] rate;
    logic [1:0]    speed_idx;
    logic          press_pulse;
    logic          key_level;
    logic          long_pulse;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: debounced level plus length of the current opposing run.
    bit m_dly0, m_dly1;
    bit m_level, m_press, m_long, m_prev_low, m_fired;
    int m_run, m_idx, m_hold;

    key_speed_ctrl #(
        .RATE_W            (RW),
        .DEBOUNCE_CYCLES   (D),
        .SPEED0            (250000),
        .SPEED1            (2500000),
        .SPEED2            (25000000),
        .SPEED3            (125000000),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .rate        (rate),
        .speed_idx   (speed_idx),
        .press_pulse (press_pulse),
        .key_level   (key_level),
        .long_pulse  (long_pulse)
    );

    always #5 clk = ~clk;

    function automatic int speed_exp(input int idx);
        case (idx)
            0:       return 250000;
            1:       return 2500000;
            2:       return 25000000;
            default: return 125000000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dly0 = 1'b1; m_dly1 = 1'b1;
        m_level = 1'b0; m_press = 1'b0; m_long = 1'b0;
        m_prev_low = 1'b0; m_fired = 1'b0;
        m_run = 0; m_idx = 0; m_hold = 0;
    endtask

    // One clock edge of the model: the key seen by the debouncer is key_n from two edges back.
    task automatic model_edge(input bit k);
        bit ks_low;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ks_low = !m_dly0;
        m_dly0 = m_dly1;
        m_dly1 = k;
        m_press = 1'b0;
        m_long  = 1'b0;
        if (!m_level) begin
            m_run = ks_low ? m_run + 1 : 0;
            if (m_run == D + 1) begin
                m_level = 1'b1; m_run = 0; m_press = 1'b1;
                m_idx = (m_idx + 1) % 4;
                m_hold = 0; m_fired = 1'b0;
            end
        end else begin
`ifdef KEY_LONG_PRESS_EN
            if (ks_low && m_prev_low && !m_fired) begin
                m_hold++;
                if (m_hold == L) begin
                    m_fired = 1'b1; m_long = 1'b1; m_idx = 0;
                end
            end
`endif
            m_run = ks_low ? 0 : m_run + 1;
            if (m_run == D + 1) begin
                m_level = 1'b0; m_run = 0;
            end
        end
        m_prev_low = ks_low;
    endtask

    task automatic cyc(input bit k);
        key_n = k;
        @(posedge clk);
        model_edge(k);
        #1;
        check("press_pulse", {31'd0, press_pulse}, {31'd0, m_press});
        check("speed_idx", {30'd0, speed_idx}, m_idx);
        check("rate", {5'd0, rate}, speed_exp(m_idx));
        check("key_level", {31'd0, key_level}, {31'd0, m_level});
        check("long_pulse", {31'd0, long_pulse}, {31'd0, m_long});
    endtask

    task automatic hold_key(input bit k, input int n);
        for (int i = 0; i < n; i++) cyc(k);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        hold_key(1'b1, n);
        rst_n = 1'b1;
    endtask

    initial begin
        int pedge, npress, nlong;
        int exp_rates [4];
        rst_n = 1'b0;
        key_n = 1'b1;
        model_reset();

        // Reset with key released.
        do_reset(3);
        check("reset_rate", {5'd0, rate}, 250000);
        check("reset_idx", {30'd0, speed_idx}, 0);
        hold_key(1'b1, 5);

        // Clean press: strobe on the (D+3)-th edge after key_n falls.
        pedge = 0; npress = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b0);
            if (press_pulse) begin
                npress++;
                if (pedge == 0) pedge = i;
            end
        end
        check("press_edge", pedge, D + 3);
        check("press_count", npress, 1);
        check("press_rate", {5'd0, rate}, 2500000);
        check("press_level", {31'd0, key_level}, 1);
        hold_key(1'b1, 10);

        // Bounce shorter than debounce window.
        npress = 0;
        for (int i = 0; i < 3; i++) begin cyc(1'b0); npress += press_pulse; end
        for (int i = 0; i < 10; i++) begin cyc(1'b1); npress += press_pulse; end
        check("bounce_press", npress, 0);
        check("bounce_idx", {30'd0, speed_idx}, 1);

        // Four presses from reset walk the table and wrap to index 0.
        exp_rates = '{2500000, 25000000, 125000000, 250000};
        do_reset(2);
        hold_key(1'b1, 3);
        for (int p = 0; p < 4; p++) begin
            hold_key(1'b0, 12);
            check("walk_rate", {5'd0, rate}, exp_rates[p]);
            hold_key(1'b1, 10);
        end
        check("walk_wrap_idx", {30'd0, speed_idx}, 0);

        // Single-cycle release glitch while held.
        hold_key(1'b0, 10);
        npress = 0;
        cyc(1'b1); npress += press_pulse;
        for (int i = 0; i < 8; i++) begin cyc(1'b0); npress += press_pulse; end
        check("glitch_press", npress, 0);
        check("glitch_level", {31'd0, key_level}, 1);
        hold_key(1'b1, 10);

        // Long hold starting from index 2.
        do_reset(2);
        hold_key(1'b1, 3);
        for (int p = 0; p < 2; p++) begin hold_key(1'b0, 10); hold_key(1'b1, 10); end
        check("pre_long_idx", {30'd0, speed_idx}, 2);
        nlong = 0;
        for (int i = 0; i < 40; i++) begin cyc(1'b0); nlong += long_pulse; end
`ifdef KEY_LONG_PRESS_EN
        check("long_count", nlong, 1);
        check("long_idx", {30'd0, speed_idx}, 0);
`else
        check("long_count", nlong, 0);
        check("long_idx", {30'd0, speed_idx}, 3);
`endif
        hold_key(1'b1, 10);

        // Reset while debounce is in progress discards the press.
        hold_key(1'b0, 5);
        rst_n = 1'b0;
        cyc(1'b0);
        rst_n = 1'b1;
        npress = 0;
        for (int i = 0; i < 12; i++) begin cyc(1'b1); npress += press_pulse; end
        check("rst_mid_press", npress, 0);
        check("rst_mid_idx", {30'd0, speed_idx}, 0);

        // Random bursty key activity.
        for (int r = 0; r < 60; r++) begin
            hold_key(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end
        hold_key(1'b1, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
